// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF (read-only) and MEM (load/store), one LAT-cycle access at a time.
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner of simultaneous requests instead of fixed MEM priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_re,
  output logic              sram_we,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              freeze_if,
  output logic              freeze_mem
);

  localparam int CNT_W = $clog2(LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
  localparam logic G_IF  = 1'b0;
  localparam logic G_MEM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              sram_re_q, sram_re_d;
  logic              sram_we_q, sram_we_d;
  logic              mem_any_s;
  logic              pick_mem_s;

  assign mem_any_s = mem_rd_req | mem_wr_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // MEM wins when alone, or when IF won the previous arbitration
  assign pick_mem_s = mem_any_s & (~if_req | (last_grant_q == G_IF));

  // Remember the winner of the most recent arbitration
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= G_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Update the winner record only when an access is launched
  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == S_IDLE) && (mem_any_s || if_req)) begin
      last_grant_d = pick_mem_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end
`else
  // MEM holds the older instruction, so it always wins a tie
  assign pick_mem_s = mem_any_s;
`endif

  // Next-state, latched request and captured read data
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_any_s || if_req) begin
          grant_d = pick_mem_s ? G_MEM : G_IF;
          addr_d  = pick_mem_s ? mem_addr : if_addr;
          wdata_d = pick_mem_s ? mem_wdata : {DATA_W{1'b0}};
          we_d    = pick_mem_s & mem_wr_req;
          cnt_d   = CNT_LOAD;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!we_q && (grant_q == G_MEM)) begin
            mem_rdata_d = sram_rdata;
          end else if (!we_q) begin
            if_rdata_d = sram_rdata;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus strobes are registered and mirror the state we are about to enter
  always_comb begin
    sram_re_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_addr_d  = {ADDR_W{1'b0}};
    sram_wdata_d = {DATA_W{1'b0}};
    if (state_d == S_ACCESS) begin
      sram_re_d    = ~we_d;
      sram_we_d    = we_d;
      sram_addr_d  = addr_d;
      sram_wdata_d = wdata_d;
    end else begin
      sram_re_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      grant_q      <= G_IF;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      if_rdata_q   <= {DATA_W{1'b0}};
      mem_rdata_q  <= {DATA_W{1'b0}};
      sram_addr_q  <= {ADDR_W{1'b0}};
      sram_wdata_q <= {DATA_W{1'b0}};
      sram_re_q    <= 1'b0;
      sram_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_re_q    <= sram_re_d;
      sram_we_q    <= sram_we_d;
    end
  end

  // A requester that withdrew during the access gets no ready pulse
  assign if_ready   = (state_q == S_DONE) && (grant_q == G_IF) && if_req;
  assign mem_ready  = (state_q == S_DONE) && (grant_q == G_MEM) && mem_any_s;
  assign freeze_if  = if_req & ~if_ready;
  assign freeze_mem = mem_any_s & ~mem_ready;

  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_re    = sram_re_q;
  assign sram_we    = sram_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (LAT=2): expected bus strobes and ready pulses are queued
// by the stimulus and checked by independent monitors. Honours ARB_ROUND_ROBIN_EN for the tie test.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd_req = 1'b0;
  logic        mem_wr_req = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_re;
  logic        sram_we;
  logic [31:0] sram_rdata;
  logic        freeze_if;
  logic        freeze_mem;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_re(sram_re), .sram_we(sram_we),
    .sram_rdata(sram_rdata), .freeze_if(freeze_if), .freeze_mem(freeze_mem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data valid only in the LAT-th strobe cycle, writes commit at that edge
  logic [31:0] mem [0:255];
  int          scnt = 0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hE3A01005;
    mem[8'h20] = 32'h0000ABCD;
  end
  assign sram_rdata = (sram_re && scnt == LAT - 1) ? mem[sram_addr[7:0]] : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (sram_we && scnt == LAT - 1) mem[sram_addr[7:0]] <= sram_wdata;
    if (rst || !(sram_re || sram_we)) scnt <= 0;
    else scnt <= scnt + 1;
  end

  typedef struct {
    int          c;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strobe_t;

  typedef struct {
    int          c;
    logic [31:0] data;
  } rdy_t;

  strobe_t sq[$];
  rdy_t    ifq[$];
  rdy_t    memq[$];

  task automatic exp_strobe(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
    strobe_t s;
    for (int k = 0; k < LAT; k++) begin
      s.c = c + k; s.re = ~we; s.we = we; s.addr = a; s.wdata = we ? d : 32'h0;
      sq.push_back(s);
    end
  endtask

  task automatic exp_if(input int c, input logic [31:0] d);
    rdy_t r;
    r.c = c; r.data = d;
    ifq.push_back(r);
  endtask

  task automatic exp_mem(input int c, input logic [31:0] d);
    rdy_t r;
    r.c = c; r.data = d;
    memq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bus monitor
  always @(negedge clk) begin
    if (sram_re === 1'b1 || sram_we === 1'b1) begin
      strobe_t s;
      n_checks++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL strobe cycle %0d: unexpected re=%b we=%b addr=%h", cyc, sram_re, sram_we, sram_addr);
      end else begin
        s = sq.pop_front();
        if (s.c != cyc || s.re !== sram_re || s.we !== sram_we || s.addr !== sram_addr ||
            (s.we && s.wdata !== sram_wdata)) begin
          n_fail++;
          $display("FAIL strobe: got cyc=%0d re=%b we=%b addr=%h wd=%h expected cyc=%0d re=%b we=%b addr=%h wd=%h",
                   cyc, sram_re, sram_we, sram_addr, sram_wdata, s.c, s.re, s.we, s.addr, s.wdata);
        end
      end
    end
  end

  // Ready monitors
  always @(negedge clk) begin
    if (if_ready === 1'b1) begin
      rdy_t r;
      n_checks++;
      if (ifq.size() == 0) begin
        n_fail++;
        $display("FAIL if_ready cycle %0d: unexpected pulse, if_rdata=%h", cyc, if_rdata);
      end else begin
        r = ifq.pop_front();
        if (r.c != cyc || r.data !== if_rdata) begin
          n_fail++;
          $display("FAIL if_ready: got cyc=%0d data=%h expected cyc=%0d data=%h", cyc, if_rdata, r.c, r.data);
        end
      end
    end
    if (mem_ready === 1'b1) begin
      rdy_t r;
      n_checks++;
      if (memq.size() == 0) begin
        n_fail++;
        $display("FAIL mem_ready cycle %0d: unexpected pulse, mem_rdata=%h", cyc, mem_rdata);
      end else begin
        r = memq.pop_front();
        if (r.c != cyc || r.data !== mem_rdata) begin
          n_fail++;
          $display("FAIL mem_ready: got cyc=%0d data=%h expected cyc=%0d data=%h", cyc, mem_rdata, r.c, r.data);
        end
      end
    end
  end

  initial begin
    int b;
    // Reset state
    at(2);
    @(negedge clk);
    chk("rst_sram_re", {31'h0, sram_re}, 32'h0);
    chk("rst_sram_we", {31'h0, sram_we}, 32'h0);
    chk("rst_sram_addr", sram_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_readys", {30'h0, if_ready, mem_ready}, 32'h0);
    at(3);
    rst = 1'b0;

    // 1: plain IF fetch
    b = 10;
    exp_strobe(b + 2, 1'b0, 32'h10, 32'h0);
    exp_if(b + 4, 32'hE3A01005);
    at(b + 1); if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk); chk("t1_freeze_c1", {31'h0, freeze_if}, 32'h1);
    at(b + 3); @(negedge clk); chk("t1_freeze_c3", {31'h0, freeze_if}, 32'h1);
    at(b + 4); @(negedge clk); chk("t1_freeze_rdy", {31'h0, freeze_if}, 32'h0);
    at(b + 5); if_req = 1'b0;

    // 2: simultaneous MEM load and IF fetch, MEM first
    b = 20;
    exp_strobe(b + 2, 1'b0, 32'h20, 32'h0);
    exp_mem(b + 4, 32'h0000ABCD);
    exp_strobe(b + 6, 1'b0, 32'h10, 32'h0);
    exp_if(b + 8, 32'hE3A01005);
    at(b + 1); if_req = 1'b1; if_addr = 32'h10; mem_rd_req = 1'b1; mem_addr = 32'h20;
    at(b + 4); @(negedge clk); chk("t2_freeze_mem_rdy", {31'h0, freeze_mem}, 32'h0);
    chk("t2_freeze_if_wait", {31'h0, freeze_if}, 32'h1);
    at(b + 5); mem_rd_req = 1'b0;
    at(b + 9); if_req = 1'b0;

    // 3: store then load back; store leaves mem_rdata alone
    b = 30;
    exp_strobe(b + 2, 1'b1, 32'h30, 32'hDEADBEEF);
    exp_mem(b + 4, 32'h0000ABCD);
    exp_strobe(b + 7, 1'b0, 32'h30, 32'h0);
    exp_mem(b + 9, 32'hDEADBEEF);
    at(b + 1); mem_wr_req = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hDEADBEEF;
    at(b + 5); mem_wr_req = 1'b0;
    at(b + 6); mem_rd_req = 1'b1;
    at(b + 10); mem_rd_req = 1'b0;

    // 4: IF flushed mid-access: bus completes, no ready, rdata still updated
    b = 42;
    exp_strobe(b + 2, 1'b0, 32'h20, 32'h0);
    at(b + 1); if_req = 1'b1; if_addr = 32'h20;
    at(b + 2); if_req = 1'b0;
    at(b + 4); @(negedge clk);
    chk("t4_no_ready", {31'h0, if_ready}, 32'h0);
    chk("t4_rdata_upd", if_rdata, 32'h0000ABCD);

    // 5: reset in the middle of an access
    b = 50;
    exp_strobe(b + 2, 1'b0, 32'h10, 32'h0);
    void'(sq.pop_back());
    at(b + 1); if_req = 1'b1; if_addr = 32'h10;
    at(b + 2); rst = 1'b1; if_req = 1'b0;
    at(b + 3); rst = 1'b0;
    @(negedge clk);
    chk("t5_re_low", {31'h0, sram_re}, 32'h0);
    chk("t5_no_ready", {30'h0, if_ready, mem_ready}, 32'h0);
    chk("t5_rdata_clr", if_rdata, 32'h0);
    exp_strobe(b + 5, 1'b0, 32'h10, 32'h0);
    exp_if(b + 7, 32'hE3A01005);
    at(b + 4); if_req = 1'b1;
    at(b + 8); if_req = 1'b0;

    // 6: both held continuously
    b = 65;
    exp_strobe(b + 2, 1'b0, 32'h20, 32'h0);
    exp_mem(b + 4, 32'h0000ABCD);
`ifdef ARB_ROUND_ROBIN_EN
    exp_strobe(b + 6, 1'b0, 32'h10, 32'h0);
    exp_if(b + 8, 32'hE3A01005);
`else
    exp_strobe(b + 6, 1'b0, 32'h20, 32'h0);
    exp_mem(b + 8, 32'h0000ABCD);
`endif
    exp_strobe(b + 10, 1'b0, 32'h20, 32'h0);
    exp_mem(b + 12, 32'h0000ABCD);
    exp_strobe(b + 14, 1'b0, 32'h10, 32'h0);
    exp_if(b + 16, 32'hE3A01005);
    at(b + 1); if_req = 1'b1; if_addr = 32'h10; mem_rd_req = 1'b1; mem_addr = 32'h20;
    at(b + 13); mem_rd_req = 1'b0;
    at(b + 17); if_req = 1'b0;

    at(95);
    chk("end_strobe_q_empty", sq.size(), 32'h0);
    chk("end_if_q_empty", ifq.size(), 32'h0);
    chk("end_mem_q_empty", memq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
